rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 33 +++
 rtl/rf_wb_arbiter_rr_select.sv | 52 +++++
 rtl/rf_wb_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
//   Shared constants and types for the register-file write-back arbiter.
//   Contents:
//     REG_W / DATA_W   register-number and write-data widths
//     ZERO_REG         hard-wired zero register; writes to it are discarded
//     NREQ_DEFAULT     default number of write-back requesters
//     SENT_DEFAULT     default starvation threshold (consecutive losses)
//     wb_beat_t        one registered register-file write
//     idx_width()      width of an index into n items (never zero)
// -----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

    localparam int REG_W        = 5;
    localparam int DATA_W       = 32;
    localparam int NREQ_DEFAULT = 3;
    localparam int SENT_DEFAULT = 8;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wb_beat_t;

    // A single requester still needs a 1-bit pointer so no vector collapses
    // to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
//   Combinational grant selection for the write-back arbiter.
//   A starving valid requester always wins (lowest index first); otherwise the
//   first valid requester at or after rr_ptr wins, wrapping to index 0.
//   Ports:
//     valid   in  NREQ   per-requester request
//     rr_ptr  in  PTR_W  round-robin search start index
//     starve  in  NREQ   per-requester starvation flag
//     grant   out NREQ   one-hot grant, zero when nothing is valid
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] rr_ptr,
    input  logic [NREQ-1:0]  starve,
    output logic [NREQ-1:0]  grant
);

    logic [NREQ-1:0] w_starving;
    logic [NREQ-1:0] w_upper;

    // Isolates the lowest set bit (v & -v).
    function automatic logic [NREQ-1:0] lowest_one(input logic [NREQ-1:0] v);
        return v & (~v + 1'b1);
    endfunction

    // NOTE: every signal driven here gets a value before any branch so the
    // block stays purely combinational and no latch is inferred.
    always_comb begin
        w_starving = valid & starve;
        w_upper    = '0;
        grant      = '0;

        // Requesters from rr_ptr upward come first in round-robin order;
        // if none of them is valid the search wraps to the bottom.
        for (int i = 0; i < NREQ; i++) begin
            w_upper[i] = valid[i] && (i >= int'(rr_ptr));
        end

        if (|w_starving) begin
            grant = lowest_one(w_starving);
        end else if (|w_upper) begin
            grant = lowest_one(w_upper);
        end else begin
            grant = lowest_one(valid);
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares one register-file write port between NREQ write-back requesters.
//   Round-robin arbitration with a starvation override; the winning write is
//   registered for one cycle onto the register-file write port. Writes to the
//   zero register are accepted and dropped.
//   Ports:
//     clk        in   system clock, rising edge
//     reset      in   asynchronous, active-high reset
//     req_valid  in   NREQ          per-requester write request
//     req_reg    in   NREQ*REG_W    destination register, slice i = requester i
//     req_data   in   NREQ*DATA_W   write data, slice i = requester i
//     req_ready  out  NREQ          one-hot accept (combinational)
//     rf_we      out  1             register-file write enable
//     rf_waddr   out  REG_W         register-file write register
//     rf_wdata   out  DATA_W        register-file write data
//     starve     out  NREQ          requester lost SENT times in a row
// -----------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int SENT = SENT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*REG_W-1:0]  req_reg,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rf_we,
    output logic [REG_W-1:0]       rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [NREQ-1:0]        starve
);

    localparam int PTR_W = idx_width(NREQ);
    localparam int CNT_W = $clog2(SENT + 1);

    localparam logic [CNT_W-1:0] SENT_CNT = CNT_W'(SENT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_loss_cnt [NREQ];
    wb_beat_t          r_beat;

    logic [NREQ-1:0]   w_starve;
    logic [NREQ-1:0]   w_grant;
    logic [PTR_W-1:0]  w_grant_idx;
    logic [REG_W-1:0]  w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_xfer;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_starve[i] = (r_loss_cnt[i] == SENT_CNT);
        end
    end

    rr_select #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .valid  (req_valid),
        .rr_ptr (r_rr_ptr),
        .starve (w_starve),
        .grant  (w_grant)
    );

    // Nothing may be accepted while reset is held, even though the pointer
    // and counters already sit at their reset values.
    assign req_ready = reset ? '0 : w_grant;
    assign w_xfer    = |req_ready;

    // The grant is one-hot, so OR-ing the selected slices forms the mux.
    always_comb begin
        w_grant_idx = '0;
        w_sel_reg   = '0;
        w_sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = w_grant_idx | PTR_W'(i);
                w_sel_reg   = w_sel_reg   | req_reg[i*REG_W +: REG_W];
                w_sel_data  = w_sel_data  | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // A counter runs only while its requester keeps asking and keeps losing;
    // dropping the request or winning starts the count over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_loss_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || w_grant[i]) begin
                    r_loss_cnt[i] <= '0;
                end else if (r_loss_cnt[i] != SENT_CNT) begin
                    r_loss_cnt[i] <= r_loss_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Output stage: the write enable is a one-cycle pulse per accepted
    // transfer; address and data keep their last value between writes.
    // Reset clears the whole beat, which cancels a write still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat <= '0;
        end else if (w_xfer) begin
            r_beat.we   <= (w_sel_reg != ZERO_REG);
            r_beat.addr <= w_sel_reg;
            r_beat.data <= w_sel_data;
        end else begin
            r_beat.we   <= 1'b0;
        end
    end

    assign rf_we    = r_beat.we;
    assign rf_waddr = r_beat.addr;
    assign rf_wdata = r_beat.data;
    assign starve   = w_starve;

endmodule
